// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave terminating the write/read channels into a bank of NUM_REGS words.
// AW and W are captured independently; commit happens on the later handshake.
module axi_lite_reg_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                    aclk_i,
    input  logic                    areset_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);

    localparam int unsigned IdxW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned StrbW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] AddrLimit  = ADDR_WIDTH'(NUM_REGS * 4);
    localparam logic [1:0]            RespOkay   = 2'b00;
    localparam logic [1:0]            RespSlvErr = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StHaveAw,
        StHaveW,
        StResp
    } wr_state_e;

    wr_state_e wr_state_q, wr_state_d;

    // Low throughout reset and until the first edge after release, so readies start at 0.
    logic rst_done_q;

    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [StrbW-1:0]      wstrb_q;
    logic [1:0]            bresp_q, bresp_d;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [StrbW-1:0]      wr_strb;
    logic                  wr_in_range, rd_in_range;
    logic [IdxW-1:0]       wr_idx, rd_idx;

    assign awready_o = rst_done_q && ((wr_state_q == StIdle) || (wr_state_q == StHaveW));
    assign wready_o  = rst_done_q && ((wr_state_q == StIdle) || (wr_state_q == StHaveAw));
    assign arready_o = rst_done_q && !rvalid_q;

    assign aw_hs = awvalid_i && awready_o;
    assign w_hs  = wvalid_i && wready_o;
    assign ar_hs = arvalid_i && arready_o;

    // A channel already held wins over the live bus; otherwise it is completing this cycle.
    assign wr_addr = (wr_state_q == StHaveAw) ? awaddr_q : awaddr_i;
    assign wr_data = (wr_state_q == StHaveW) ? wdata_q : wdata_i;
    assign wr_strb = (wr_state_q == StHaveW) ? wstrb_q : wstrb_i;

    assign wr_in_range = wr_addr < AddrLimit;
    assign wr_idx      = wr_addr[2 +: IdxW];
    assign rd_in_range = araddr_i < AddrLimit;
    assign rd_idx      = araddr_i[2 +: IdxW];

    always_comb begin
        wr_state_d = wr_state_q;
        commit     = 1'b0;
        unique case (wr_state_q)
            StIdle: begin
                if (aw_hs && w_hs) begin
                    wr_state_d = StResp;
                    commit     = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = StHaveAw;
                end else if (w_hs) begin
                    wr_state_d = StHaveW;
                end
            end
            StHaveAw: begin
                if (w_hs) begin
                    wr_state_d = StResp;
                    commit     = 1'b1;
                end
            end
            StHaveW: begin
                if (aw_hs) begin
                    wr_state_d = StResp;
                    commit     = 1'b1;
                end
            end
            StResp: begin
                if (bready_i) begin
                    wr_state_d = StIdle;
                end
            end
            default: wr_state_d = StIdle;
        endcase
    end

    always_comb begin
        bresp_d = bresp_q;
        if (commit) begin
            bresp_d = wr_in_range ? RespOkay : RespSlvErr;
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? mem_q[rd_idx] : '0;
            rresp_d  = rd_in_range ? RespOkay : RespSlvErr;
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            rst_done_q <= 1'b0;
            wr_state_q <= StIdle;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RespOkay;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
        end else begin
            rst_done_q <= 1'b1;
            wr_state_q <= wr_state_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            if (aw_hs) begin
                awaddr_q <= awaddr_i;
            end
            if (w_hs) begin
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
        end
    end

    // Reads sample mem_q before this edge's write lands, so same-edge reads see old data.
    always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && wr_in_range) begin
            for (int b = 0; b < StrbW; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign bvalid_o = (wr_state_q == StResp);
    assign bresp_o  = bresp_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave: directed table, hand sequences for
// ordering/backpressure/reset corners, and random traffic against a word-array model.
module tb_axi_lite_reg_slave;

    localparam int NumRegs = 32;

    logic        aclk, areset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model [NumRegs];

    axi_lite_reg_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NumRegs)
    ) dut (
        .aclk_i    (aclk),
        .areset_i  (areset),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rvalid_o  (rvalid),
        .rready_i  (rready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        int idx;
        if (a >= 32'(NumRegs * 4)) return 2'b10;
        idx = int'(a >> 2);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a >= 32'(NumRegs * 4)) return 32'h0;
        return model[int'(a >> 2)];
    endfunction

    function automatic logic [1:0] model_rresp(input logic [31:0] a);
        return (a >= 32'(NumRegs * 4)) ? 2'b10 : 2'b00;
    endfunction

    // All timing is done at negedges: outputs are sampled, then inputs set for the next edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int bdly,
                             output logic [1:0] resp);
        bit aw_hs, w_hs, aw_done, w_done;
        int c;
        logic [1:0] r;
        aw_hs = 0; w_hs = 0; aw_done = 0; w_done = 0; c = 0;
        while (c < 40) begin
            @(negedge aclk);
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin wvalid = 1'b0; w_done = 1; end
            if (aw_done && w_done) break;
            check("b_early", 32'(bvalid), 32'h0);
            if (aw_done) check("awready_held", 32'(awready), 32'h0);
            if (w_done) check("wready_held", 32'(wready), 32'h0);
            if (c == aw_dly) begin awaddr = a; awvalid = 1'b1; end
            if (c == w_dly) begin wdata = d; wstrb = s; wvalid = 1'b1; end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            c++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_handshake", 32'({aw_done, w_done}), 32'h3);
        check("b_latency", 32'(bvalid), 32'h1);
        r = bresp;
        repeat (bdly) begin
            @(negedge aclk);
            check("b_hold", 32'(bvalid), 32'h1);
            check("bresp_hold", 32'(bresp), 32'(r));
            check("ready_stall", 32'({awready, wready}), 32'h0);
        end
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("b_clear", 32'(bvalid), 32'h0);
        resp = r;
    endtask

    task automatic axi_read(input logic [31:0] a, input int ar_dly, input int rdly,
                            output logic [31:0] d, output logic [1:0] resp);
        bit hs, done;
        int c;
        hs = 0; done = 0; c = 0;
        while (c < 40) begin
            @(negedge aclk);
            if (hs) begin done = 1; break; end
            if (c == ar_dly) begin araddr = a; arvalid = 1'b1; end
            hs = arvalid && arready;
            c++;
        end
        arvalid = 1'b0;
        check("ar_handshake", 32'(done), 32'h1);
        check("r_latency", 32'(rvalid), 32'h1);
        d = rdata;
        resp = rresp;
        repeat (rdly) begin
            @(negedge aclk);
            check("r_hold", 32'(rvalid), 32'h1);
            check("rdata_hold", rdata, d);
            check("arready_stall", 32'(arready), 32'h0);
        end
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        check("r_clear", 32'(rvalid), 32'h0);
    endtask

    task automatic bank_check();
        logic [31:0] d;
        logic [1:0]  r;
        for (int k = 0; k < NumRegs; k++) begin
            axi_read(32'(k * 4), 0, 0, d, r);
            check("bank_rdata", d, model_rdata(32'(k * 4)));
            check("bank_rresp", 32'(r), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] d, a, old;
        logic [3:0]  s;
        logic [1:0]  r, er;

        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        areset = 1'b1;
        for (int i = 0; i < NumRegs; i++) model[i] = 32'h0;

        vecs[0] = '{32'h08, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{32'h10, 32'hFFFFFFFF, 4'hF, 2'b00, 32'hFFFFFFFF, 2'b00};
        vecs[2] = '{32'h10, 32'h00000000, 4'h5, 2'b00, 32'hFF00FF00, 2'b00};
        vecs[3] = '{32'h80, 32'h12345678, 4'hF, 2'b10, 32'h00000000, 2'b10};
        vecs[4] = '{32'h0B, 32'hAABBCCDD, 4'h2, 2'b00, 32'hDEADCCEF, 2'b00};
        vecs[5] = '{32'h7C, 32'hCAFEF00D, 4'h8, 2'b00, 32'hCA000000, 2'b00};
        vecs[6] = '{32'h04, 32'h00000055, 4'h0, 2'b00, 32'h00000000, 2'b00};
        vecs[7] = '{32'hFFFFFFFC, 32'h00000001, 4'hF, 2'b10, 32'h00000000, 2'b10};

        // Reset state
        repeat (3) @(negedge aclk);
        check("rst_readies", 32'({awready, wready, arready}), 32'h0);
        check("rst_valids", 32'({bvalid, rvalid}), 32'h0);
        check("rst_resps", 32'({bresp, rresp}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        areset = 1'b0;
        @(negedge aclk);
        check("post_rst_readies", 32'({awready, wready, arready}), 32'h7);

        // Directed table
        for (int v = 0; v < 8; v++) begin
            axi_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb, 0, 0, 0, r);
            void'(model_write(vecs[v].addr, vecs[v].wdata, vecs[v].strb));
            check("tbl_bresp", 32'(r), 32'(vecs[v].bresp));
            axi_read(vecs[v].addr, 0, 0, d, r);
            check("tbl_rdata", d, vecs[v].rdata);
            check("tbl_rresp", 32'(r), 32'(vecs[v].rresp));
        end

        // W three cycles ahead of AW, then AW ahead of W
        axi_write(32'h10, 32'h11223344, 4'hF, 3, 0, 0, r);
        er = model_write(32'h10, 32'h11223344, 4'hF);
        check("w_first_bresp", 32'(r), 32'(er));
        axi_read(32'h10, 0, 0, d, r);
        check("w_first_rdata", d, 32'h11223344);
        axi_write(32'h14, 32'h55667788, 4'hF, 0, 3, 0, r);
        er = model_write(32'h14, 32'h55667788, 4'hF);
        check("aw_first_bresp", 32'(r), 32'(er));
        axi_read(32'h14, 0, 0, d, r);
        check("aw_first_rdata", d, 32'h55667788);

        // Same-edge read and write of one register returns the old value
        old = model_rdata(32'h08);
        @(negedge aclk);
        awaddr = 32'h08; awvalid = 1; wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1;
        araddr = 32'h08; arvalid = 1;
        check("same_edge_readies", 32'({awready, wready, arready}), 32'h7);
        @(negedge aclk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("same_edge_bvalid", 32'(bvalid), 32'h1);
        check("same_edge_rvalid", 32'(rvalid), 32'h1);
        check("same_edge_rdata", rdata, old);
        void'(model_write(32'h08, 32'h01020304, 4'hF));
        bready = 1; rready = 1;
        @(negedge aclk);
        bready = 0; rready = 0;
        check("same_edge_clear", 32'({bvalid, rvalid}), 32'h0);
        axi_read(32'h08, 0, 0, d, r);
        check("same_edge_new", d, 32'h01020304);

        // Out-of-range write with bready stalled; bank must be unchanged
        axi_write(32'h80, 32'hA5A5A5A5, 4'hF, 0, 0, 5, r);
        check("oor_bp_bresp", 32'(r), 32'h2);
        bank_check();

        // Read stall with a second AR pending
        @(negedge aclk);
        araddr = 32'h10; arvalid = 1;
        @(negedge aclk);
        araddr = 32'h14;
        check("rbp_first", rdata, model_rdata(32'h10));
        repeat (4) begin
            @(negedge aclk);
            check("rbp_arready", 32'(arready), 32'h0);
            check("rbp_rvalid", 32'(rvalid), 32'h1);
            check("rbp_rdata", rdata, model_rdata(32'h10));
        end
        rready = 1;
        @(negedge aclk);
        rready = 0;
        check("rbp_reopen", 32'(arready), 32'h1);
        @(negedge aclk);
        arvalid = 0;
        check("rbp_second_valid", 32'(rvalid), 32'h1);
        check("rbp_second_rdata", rdata, model_rdata(32'h14));
        rready = 1;
        @(negedge aclk);
        rready = 0;

        // Random traffic against the model
        for (int n = 0; n < 200; n++) begin
            a = 32'($urandom_range(0, 39)) * 32'd4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          int'($urandom_range(0, 2)), r);
                er = model_write(a, d, s);
                check("rnd_bresp", 32'(r), 32'(er));
            end else begin
                axi_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), d, r);
                check("rnd_rdata", d, model_rdata(a));
                check("rnd_rresp", 32'(r), 32'(model_rresp(a)));
            end
        end
        bank_check();

        // Reset with only AW held
        @(negedge aclk);
        awaddr = 32'h0C; awvalid = 1;
        @(negedge aclk);
        awvalid = 0;
        check("aw_only_ready", 32'({awready, wready}), 32'h1);
        #2 areset = 1'b1;
        #1;
        check("mid_rst_readies", 32'({awready, wready, arready}), 32'h0);
        wdata = 32'h99999999; wstrb = 4'hF;
        repeat (2) begin
            @(negedge aclk);
            check("mid_rst_bvalid", 32'(bvalid), 32'h0);
        end
        areset = 1'b0;
        @(negedge aclk);
        check("rel_readies", 32'({awready, wready, arready}), 32'h7);
        check("rel_bvalid", 32'(bvalid), 32'h0);
        @(negedge aclk);
        check("rel_bvalid2", 32'(bvalid), 32'h0);
        for (int i = 0; i < NumRegs; i++) model[i] = 32'h0;
        bank_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
